// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter: round-robin sharing of one word-serial memory port between
// an instruction and a data cache, sequencing block refills and single-word writes.
module cache_refill_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30,
  parameter int BLOCK_SIZE    = 3,
  localparam int JUST_DATA    = DATA_WIDTH * (2 ** BLOCK_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               req,
  input  logic [1:0]               we,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic [1:0]               grant,
  output logic [1:0]               done,
  output logic [JUST_DATA-1:0]     blk_out,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t                   state_q, state_d;
  logic                     owner_q, owner_d, we_q, we_d, last_q, last_d, sel;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [BLOCK_SIZE-1:0]    cnt_q, cnt_d;
  logic [JUST_DATA-1:0]     blk_q, blk_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    // on a tie the port that did not win last time goes first
    sel     = (req == 2'b11) ? ~last_q : req[1];
    case (state_q)
      IDLE: if (|req) begin
        owner_d = sel;
        we_d    = we[sel];
        addr_d  = sel ? addr1 : addr0;
        wdata_d = sel ? wdata1 : wdata0;
        last_d  = sel;
        cnt_d   = '0;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (mem_rvalid) begin
        if (we_q) state_d = DONE;
        else begin
          blk_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
          state_d = (&cnt_q) ? DONE : ISSUE;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign grant     = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign done      = (state_q == DONE) ? grant : 2'b00;
  assign mem_req   = state_q == ISSUE;
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = !mem_req ? '0 : we_q ? addr_q : {addr_q[ADDRESS_WIDTH-1:BLOCK_SIZE], cnt_q};
  assign mem_wdata = mem_we ? wdata_q : '0;
  assign blk_out   = blk_q;
endmodule
